// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, opcode width and immediate-opcode decode for fetch_ctrl
package fetch_pkg;

    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_LDM  = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_IADD = 6'b001101;

    typedef enum logic [1:0] {
        S_FETCH,
        S_IMM
`ifdef FETCH_CTRL_INT_EN
        ,
        S_INT
`endif
    } state_t;

    // Opcodes whose instruction is followed by a second (immediate) word
    function automatic logic has_imm(input logic [OPCODE_W-1:0] opcode);
        return (opcode == OP_LDM) || (opcode == OP_IADD);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: 32-bit program counter with increment enable and parallel load
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ld,
    input  logic [31:0] ld_pc,
    output logic [31:0] pc_o
);

    logic [31:0] pc_d, pc_q;

    // Load wins over increment; increment wraps modulo 2^32
    always_comb pc_d = ld ? ld_pc : en ? pc_q + 32'd1 : pc_q;

    // Synchronous active-low reset to the boot address
    always_ff @(posedge clk) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch FSM with one/two-word decode, stall, redirect; interrupts when FETCH_CTRL_INT_EN is defined
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INT_PC   = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        int_req_i,
    input  logic [15:0] imem_rdata_i,
    output logic [31:0] imem_addr_o,
    output logic        inst_valid_o,
    output logic [15:0] inst_o,
    output logic [15:0] imm_o,
    output logic [31:0] inst_pc_o,
    output logic        int_ack_o,
    output logic [31:0] epc_o
);

    state_t      state_d, state_q;
    logic        valid_d, valid_q;
    logic [15:0] inst_d, inst_q;
    logic [15:0] imm_d, imm_q;
    logic [31:0] inst_pc_d, inst_pc_q;
    logic        pc_inc, pc_ld;
    logic [31:0] pc;
`ifdef FETCH_CTRL_INT_EN
    logic        ack_d, ack_q;
    logic [31:0] epc_d, epc_q;
`endif

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk   (clk),
        .rst   (rst),
        .en    (pc_inc),
        .ld    (pc_ld),
        .ld_pc (redirect_i ? redirect_pc_i : INT_PC),
        .pc_o  (pc)
    );

    // Next-state: redirect beats everything, then interrupt exit, then stall hold, then fetch/immediate
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        imm_d     = imm_q;
        inst_pc_d = inst_pc_q;
        pc_inc    = 1'b0;
        pc_ld     = 1'b0;
`ifdef FETCH_CTRL_INT_EN
        ack_d     = 1'b0;
        epc_d     = epc_q;
`endif
        if (redirect_i) begin
            state_d = S_FETCH;
            valid_d = 1'b0;
            pc_ld   = 1'b1;
        end
`ifdef FETCH_CTRL_INT_EN
        else if (state_q == S_INT) begin
            state_d = S_FETCH;
        end
`endif
        else if (!stall_i) begin
            if (state_q == S_IMM) begin
                imm_d   = imem_rdata_i;
                pc_inc  = 1'b1;
                valid_d = 1'b1;
                state_d = S_FETCH;
            end
`ifdef FETCH_CTRL_INT_EN
            else if (int_req_i) begin
                state_d = S_INT;
                epc_d   = pc;
                pc_ld   = 1'b1;
                valid_d = 1'b0;
                ack_d   = 1'b1;
            end
`endif
            else begin
                inst_d    = imem_rdata_i;
                inst_pc_d = pc;
                imm_d     = 16'h0000;
                pc_inc    = 1'b1;
                valid_d   = !has_imm(imem_rdata_i[15:10]);
                state_d   = has_imm(imem_rdata_i[15:10]) ? S_IMM : S_FETCH;
            end
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            valid_q   <= 1'b0;
            inst_q    <= 16'h0000;
            imm_q     <= 16'h0000;
            inst_pc_q <= 32'h0000_0000;
`ifdef FETCH_CTRL_INT_EN
            ack_q     <= 1'b0;
            epc_q     <= 32'h0000_0000;
`endif
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            imm_q     <= imm_d;
            inst_pc_q <= inst_pc_d;
`ifdef FETCH_CTRL_INT_EN
            ack_q     <= ack_d;
            epc_q     <= epc_d;
`endif
        end
    end

    assign imem_addr_o  = pc;
    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign imm_o        = imm_q;
    assign inst_pc_o    = inst_pc_q;
`ifdef FETCH_CTRL_INT_EN
    assign int_ack_o    = ack_q;
    assign epc_o        = epc_q;
`else
    logic unused_int_req;
    assign unused_int_req = int_req_i;
    assign int_ack_o      = 1'b0;
    assign epc_o          = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl (interrupt checks follow FETCH_CTRL_INT_EN)
module tb_fetch_ctrl;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] imm;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall_i, redirect_i, int_req_i;
    logic [31:0] redirect_pc_i;
    logic [15:0] imem_rdata_i;
    logic [31:0] imem_addr_o, inst_pc_o, epc_o;
    logic        inst_valid_o, int_ack_o;
    logic [15:0] inst_o, imm_o;

    logic [15:0] mem [0:255];
    exp_t        sb [$];
    logic        adv = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .int_req_i     (int_req_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_addr_o   (imem_addr_o),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .imm_o         (imm_o),
        .inst_pc_o     (inst_pc_o),
        .int_ack_o     (int_ack_o),
        .epc_o         (epc_o)
    );

    always #5 clk = ~clk;

    assign imem_rdata_i = mem[imem_addr_o[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [15:0] imm);
        exp_t e;
        e.inst = mem[a[7:0]];
        e.imm  = imm;
        e.pc   = a;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, imem_addr_o, 32'h0);
        chk({tag, "_valid"}, {31'b0, inst_valid_o}, 32'h0);
        chk({tag, "_inst"}, {16'b0, inst_o}, 32'h0);
        chk({tag, "_imm"}, {16'b0, imm_o}, 32'h0);
        chk({tag, "_ipc"}, inst_pc_o, 32'h0);
        chk({tag, "_ack"}, {31'b0, int_ack_o}, 32'h0);
        chk({tag, "_epc"}, epc_o, 32'h0);
    endtask

    // An edge advances the pipeline only when out of reset, unstalled and not redirected
    always @(posedge clk) adv <= rst && !stall_i && !redirect_i;

    // Every valid output produced by an advancing edge is a new instruction
    always @(negedge clk) begin
        if (adv && inst_valid_o) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {16'b0, inst_o}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_inst", {16'b0, inst_o}, {16'b0, e.inst});
                chk("sb_imm", {16'b0, imm_o}, {16'b0, e.imm});
                chk("sb_pc", inst_pc_o, e.pc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h4000 | 16'(i);
        mem[0] = 16'h0410;
        mem[1] = 16'h0005;
        mem[2] = 16'h2D10;
        mem[3] = 16'h0123;
        mem[4] = 16'h3404;
        mem[5] = 16'h00AA;
        rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; int_req_i = 1'b0;
        redirect_pc_i = 32'h0;
        cyc(); cyc();
        chk_zero("rst");

        push(0, 16'h0005);
        push(2, 16'h0000);
        push(3, 16'h0000);
        rst = 1'b1;
        cyc();
        chk("first_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("first_addr", imem_addr_o, 32'h1);
        cyc();
        chk("ldm_valid", {31'b0, inst_valid_o}, 32'h1);
        cyc(); cyc();
        chk("addr4", imem_addr_o, 32'h4);

        push(4, 16'h00AA);
        cyc();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_addr", imem_addr_o, 32'h5);
            chk("stall_valid", {31'b0, inst_valid_o}, 32'h0);
            chk("stall_inst", {16'b0, inst_o}, 32'h3404);
        end
        stall_i = 1'b0;
        cyc();
        chk("resume_addr", imem_addr_o, 32'h6);

        redirect_i = 1'b1; redirect_pc_i = 32'h5;
        cyc();
        chk("redir5_addr", imem_addr_o, 32'h5);
        chk("redir5_valid", {31'b0, inst_valid_o}, 32'h0);
        redirect_i = 1'b0;
        int_req_i = 1'b1;
`ifdef FETCH_CTRL_INT_EN
        cyc();
        chk("int_ack", {31'b0, int_ack_o}, 32'h1);
        chk("int_epc", epc_o, 32'h5);
        chk("int_addr", imem_addr_o, 32'h10);
        chk("int_valid", {31'b0, inst_valid_o}, 32'h0);
        int_req_i = 1'b0;
        cyc();
        chk("int_ack_end", {31'b0, int_ack_o}, 32'h0);
        chk("int_epc_hold", epc_o, 32'h5);
        chk("int_addr_hold", imem_addr_o, 32'h10);
        push(32'h10, 16'h0000);
        cyc();
        redirect_i = 1'b1; redirect_pc_i = 32'h5;
        cyc();
        redirect_i = 1'b0; int_req_i = 1'b1;
        cyc();
        chk("int2_ack", {31'b0, int_ack_o}, 32'h1);
        int_req_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h40;
        cyc();
        chk("int_redir_addr", imem_addr_o, 32'h40);
        chk("int_redir_ack", {31'b0, int_ack_o}, 32'h0);
        chk("int_redir_valid", {31'b0, inst_valid_o}, 32'h0);
        redirect_i = 1'b0;
`else
        push(5, 16'h0000);
        cyc();
        chk("noint_ack", {31'b0, int_ack_o}, 32'h0);
        chk("noint_epc", epc_o, 32'h0);
        chk("noint_addr", imem_addr_o, 32'h6);
        int_req_i = 1'b0;
`endif

        redirect_i = 1'b1; redirect_pc_i = 32'h0;
        cyc();
        redirect_i = 1'b0;
        cyc();
        chk("imm_state_valid", {31'b0, inst_valid_o}, 32'h0);
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        cyc();
        chk("redir_imm_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("redir_imm_addr", imem_addr_o, 32'h40);
        redirect_i = 1'b0;
        push(32'h40, 16'h0000);
        cyc();

        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        cyc();
        chk("redir_stall_addr", imem_addr_o, 32'hFFFF_FFFF);
        chk("redir_stall_valid", {31'b0, inst_valid_o}, 32'h0);
        stall_i = 1'b0; redirect_i = 1'b0;
        push(32'hFFFF_FFFF, 16'h0000);
        cyc();
        chk("wrap_addr", imem_addr_o, 32'h0);

        redirect_i = 1'b1; redirect_pc_i = 32'h0;
        cyc();
        redirect_i = 1'b0;
        cyc();
        chk("pre_rst_addr", imem_addr_o, 32'h1);
        rst = 1'b0;
        cyc();
        chk_zero("rst_imm");
        rst = 1'b1;
        cyc();

        chk("sb_left", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL use one clock `clk` and one reset `rst`; `rst` is synchronous and active-low.
REQ-002 Parameters SHALL be:
- RESET_PC, default 32'h0000_0000: first fetch address after reset.
- INT_PC, default 32'h0000_0010: interrupt entry address.
REQ-003 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- stall_i  in  1  hold fetch (hazard).
- redirect_i  in  1  branch/jump redirect valid.
- redirect_pc_i  in  32  redirect target.
- int_req_i  in  1  interrupt request (level).
- imem_rdata_i  in  16  instruction word at imem_addr_o, valid the same cycle.
- imem_addr_o  out  32  fetch address, equals pc register combinationally.
- inst_valid_o  out  1  inst_o/imm_o/inst_pc_o hold a complete instruction.
- inst_o  out  16  instruction word {opcode[15:10], src[9:7], dst[6:4], shamt[3:0]}.
- imm_o  out  16  immediate word; 0 for single-word instructions.
- inst_pc_o  out  32  address of inst_o.
- int_ack_o  out  1  one-cycle pulse on interrupt entry.
- epc_o  out  32  saved return address.

Function
REQ-004 The block SHALL implement states S_FETCH, S_IMM and S_INT.
REQ-005 In S_FETCH with no stall and no redirect, the block SHALL perform all of the following:
- capture imem_rdata_i.
- set the internal pc to pc+1 (32-bit modulo wrap: 32'hFFFF_FFFF -> 0).
- record the instruction address.
REQ-006 If the captured opcode is in the package immediate set, the block SHALL:
- enter S_IMM with inst_valid_o=0.
- on the next non-stalled cycle, capture imem_rdata_i into imm_o, set pc to pc+1, assert inst_valid_o and return to S_FETCH.
REQ-007 If the captured opcode is not in the immediate set, the block SHALL set imm_o=0 and assert inst_valid_o=1 in the next cycle, giving one-cycle latency from address to valid output.
REQ-008 While stall_i=1 and redirect_i=0, the block SHALL hold pc, state and all outputs unchanged.
REQ-009 redirect_i SHALL have highest priority and override stall_i and interrupts; when it is asserted, the block SHALL:
- set pc to redirect_pc_i and state to S_FETCH.
- set inst_valid_o=0, discarding any partial S_IMM instruction.
REQ-010 int_req_i SHALL be sampled only in S_FETCH with stall_i=0 and redirect_i=0, i.e. at an instruction boundary; a request arriving in S_IMM is deferred until that instruction completes.
REQ-011 On interrupt entry, the block SHALL do all of the following in one step:
- set epc_o to the current pc, which is not yet fetched.
- set pc to INT_PC and inst_valid_o=0.
- pulse int_ack_o high for exactly one cycle in S_INT, then return to S_FETCH.
REQ-012 inst_valid_o SHALL be 0 in S_INT, and a redirect in S_INT SHALL still win.

Reset
REQ-013 While rst=0 at a clock edge, the block SHALL set:
- pc to RESET_PC and state to S_FETCH.
- inst_valid_o=0, inst_o=0, imm_o=0, inst_pc_o=0, int_ack_o=0 and epc_o=0.
REQ-014 Reset asserted mid-S_IMM or in S_INT SHALL abandon the operation with no residual output.

Configuration
REQ-015 Macro FETCH_CTRL_INT_EN SHALL control interrupt support:
- defined: REQ-010 to REQ-012 apply.
- undefined: S_INT is absent, int_req_i is ignored, and int_ack_o and epc_o are tied to 0.

Structure
REQ-016 Package fetch_pkg SHALL hold:
- the state enum.
- the OPCODE_W=6 constant.
- the immediate opcode set: LDM 6'b000001 and IADD 6'b001101.
- the function has_imm(opcode).
REQ-017 One sub-module, fetch_pc_reg (32-bit pc register with enable and load), SHALL hold the pc.

Verification
REQ-018 Reset release with memory {0:16'h0410 (LDM), 1:16'h0005, 2:16'h2D10} SHALL give inst_o=16'h0410, imm_o=16'h0005, inst_pc_o=0 at cycle 2, then inst_o=16'h2D10, imm_o=0 at cycle 3.
REQ-019 stall_i held 3 cycles mid-stream SHALL freeze imem_addr_o and all outputs, then resume with no skipped or duplicated word.
REQ-020 redirect_i with redirect_pc_i=32'h40 during S_IMM SHALL give inst_valid_o=0 next cycle and imem_addr_o=32'h40.
REQ-021 int_req_i at pc=5 (FETCH_CTRL_INT_EN defined) SHALL give int_ack_o one pulse, epc_o=5 and imem_addr_o=32'h10; the same stimulus with the macro undefined SHALL give no change.
REQ-022 redirect_i and stall_i together SHALL take the redirect, and pc=32'hFFFF_FFFF SHALL wrap to 0.
REQ-023 rst=0 asserted in S_IMM SHALL give imem_addr_o=RESET_PC and all outputs 0 next cycle.
